// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the serial sequence detector.
// State indices count how many leading pattern bits are currently matched.
package seqdet_pkg;

  localparam int PAT_W_MAX = 16;
  localparam int IDX_W_MAX = $clog2(PAT_W_MAX + 1);

  // Wide enough for any legal pattern length; per-instance ports use idx_w().
  typedef logic [IDX_W_MAX-1:0] seq_idx_t;

  function automatic int idx_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // The MATCH state sits one past the last partial-match state.
  function automatic int match_idx(input int pat_w);
    return pat_w;
  endfunction

endpackage

// File: rtl/seqdet_prefix_match.sv
// Next-state search: the longest pattern prefix that ends the candidate bit sequence.
// Purely combinational; the candidate is hist_i (newest in LSB) followed by bit_i.
module seqdet_prefix_match
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int IW    = idx_w(PAT_W)
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic             bit_i,
  input  logic [IW-1:0]    cur_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             overlap_i,
  output logic [IW-1:0]    nxt_o
);

  localparam logic [IW-1:0] MATCH_IDX = IW'(match_idx(PAT_W));

  int   eff_cur;
  int   k_max;
  logic hit;

  // Leaving MATCH without overlap forgets history, so only bit_i may start a new match.
  always_comb begin
    eff_cur = int'(cur_i);
    if ((cur_i == MATCH_IDX) && !overlap_i) begin
      eff_cur = 0;
    end
    k_max = (eff_cur + 1 > PAT_W) ? PAT_W : eff_cur + 1;
  end

  // Ascending k, so the largest matching prefix is the one that sticks.
  always_comb begin
    nxt_o = '0;
    hit   = 1'b0;
    for (int k = 1; k <= PAT_W; k++) begin
      hit = (k <= k_max) && (bit_i == pat_i[PAT_W-k]);
      for (int j = 0; j < PAT_W - 1; j++) begin
        if ((j + 1 < k) && (hist_i[j] != pat_i[PAT_W-k+j+1])) begin
          hit = 1'b0;
        end
      end
      if (hit) begin
        nxt_o = IW'(k);
      end
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with a runtime-loadable pattern and overlap control.
// Optional saturating match counter enabled by the SEQDET_MATCH_CNT_EN macro.
module moore_seq_detector
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011),
  parameter int               CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic                       overlap_en,
  output logic                       match,
  output logic                       match_pulse,
  output logic [$clog2(PAT_W+1)-1:0] prog,
  output logic [CNT_W-1:0]           match_cnt,
  input  logic                       cnt_clr
);

  localparam int IW = idx_w(PAT_W);

  localparam logic [IW-1:0] S0    = '0;
  localparam logic [IW-1:0] MATCH = IW'(match_idx(PAT_W));

  logic [IW-1:0]    state_q, state_d;
  logic [PAT_W-1:0] hist_q,  hist_d;
  logic [PAT_W-1:0] pat_q,   pat_d;
  logic             pulse_q, pulse_d;
  logic [IW-1:0]    nxt_idx;

  seqdet_prefix_match #(
    .PAT_W (PAT_W),
    .IW    (IW)
  ) u_prefix (
    .hist_i    (hist_q),
    .bit_i     (in_bit),
    .cur_i     (state_q),
    .pat_i     (pat_q),
    .overlap_i (overlap_en),
    .nxt_o     (nxt_idx)
  );

  // in_valid qualifies in_bit for exactly one rising edge; there is no backpressure,
  // and pat_load in the same cycle discards the bit.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    pulse_d = 1'b0;
    if (pat_load) begin
      pat_d   = pat_in;
      state_d = S0;
      hist_d  = '0;
    end else if (in_valid) begin
      state_d = nxt_idx;
      hist_d  = {hist_q[PAT_W-2:0], in_bit};
      pulse_d = (nxt_idx == MATCH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S0;
      hist_q  <= '0;
      pat_q   <= RST_PAT;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      pulse_q <= pulse_d;
    end
  end

  // Outputs decode registered state only; prog doubles as the FSM debug view.
  assign match       = (state_q == MATCH);
  assign match_pulse = pulse_q;
  assign prog        = state_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts registered pulses; a clear in the same cycle takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pulse_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: suffix/prefix stream model plus literal checkpoints.
module tb_moore_seq_detector;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             overlap_en = 1'b1;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic             match_pulse;
  logic [2:0]       prog;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  bit checking_on = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  moore_seq_detector #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .overlap_en  (overlap_en),
    .match       (match),
    .match_pulse (match_pulse),
    .prog        (prog),
    .match_cnt   (match_cnt),
    .cnt_clr     (cnt_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Keeps the recent bit stream since the last restart point and asks which
  // pattern prefix is the longest suffix of it.
  logic [PAT_W-1:0] m_pat = 4'b1011;
  bit               m_stream[$];
  int               m_k = 0;
  bit               m_pulse = 1'b0;
  int               m_cnt = 0;

  function automatic int longest(input bit s[$], input logic [PAT_W-1:0] p);
    int n;
    bit ok;
    n = (s.size() < PAT_W) ? s.size() : PAT_W;
    for (int k = n; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (s[s.size()-k+i] != p[PAT_W-1-i]) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit old_pulse;
    old_pulse = m_pulse;
    if (pat_load) begin
      m_pat = pat_in;
      m_stream.delete();
      m_k = 0;
      m_pulse = 1'b0;
    end else if (in_valid) begin
      if (m_k == PAT_W && !overlap_en) m_stream.delete();
      m_stream.push_back(in_bit);
      if (m_stream.size() > PAT_W) void'(m_stream.pop_front());
      m_k = longest(m_stream, m_pat);
      m_pulse = (m_k == PAT_W);
    end else begin
      m_pulse = 1'b0;
    end
    if (CNT_ON) begin
      if (cnt_clr) m_cnt = 0;
      else if (old_pulse && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pat = 4'b1011;
      m_stream.delete();
      m_k = 0;
      m_pulse = 1'b0;
      m_cnt = 0;
    end else begin
      model_edge();
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (checking_on) begin
      check("cyc_match", int'(match), int'(m_k == PAT_W));
      check("cyc_pulse", int'(match_pulse), int'(m_pulse));
      check("cyc_prog", int'(prog), m_k);
      check("cyc_cnt", int'(match_cnt), m_cnt);
    end
    if (match_pulse === 1'b1) pulses++;
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic b, input logic ld = 1'b0,
                       input logic [PAT_W-1:0] p = '0, input logic clr = 1'b0);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    pat_load = ld;
    pat_in   = p;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    #2 reset_n = 1'b0;
    #1;
    check("rst_match", int'(match), 0);
    check("rst_pulse", int'(match_pulse), 0);
    check("rst_prog", int'(prog), 0);
    check("rst_cnt", int'(match_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checking_on = 1'b1;

    // overlap: 1011011 matches twice
    pulses = 0;
    overlap_en = 1'b1;
    send_bits(16'b1011, 4);
    check("t1_match_b4", int'(match), 1);
    send_bits(16'b011, 3);
    check("t1_prog_b7", int'(prog), 4);
    drive(1'b0, 1'b0);
    check("t1_pulses", pulses, 2);
    check("t1_cnt", int'(match_cnt), CNT_ON ? 2 : 0);

    // non-overlap: same stream matches once
    drive(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    pulses = 0;
    overlap_en = 1'b0;
    send_bits(16'b1011011, 7);
    check("t2_prog_b7", int'(prog), 1);
    check("t2_match_b7", int'(match), 0);
    drive(1'b0, 1'b0);
    check("t2_pulses", pulses, 1);
    check("t2_cnt", int'(match_cnt), CNT_ON ? 1 : 0);

    // all-ones pattern, overlap: MATCH held for 5 bits, counter saturates
    drive(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    pulses = 0;
    hi = 0;
    overlap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1);
      if (match) hi++;
    end
    drive(1'b0, 1'b0);
    check("t3_match_cycles", hi, 5);
    check("t3_pulses", pulses, 5);
    check("t3_cnt_sat", int'(match_cnt), CNT_ON ? 3 : 0);
    drive(1'b1, 1'b1);
    check("t3_reentry_pulse", int'(match_pulse), 1);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    check("t3_clr_wins", int'(match_cnt), 0);

    // all-ones pattern, non-overlap: pulses after bits 4 and 8
    drive(1'b0, 1'b0, 1'b1, 4'b1111);
    pulses = 0;
    overlap_en = 1'b0;
    send_bits(16'hFF, 8);
    drive(1'b0, 1'b0);
    check("t3n_pulses", pulses, 2);

    // pat_load beats in_valid in the same cycle
    drive(1'b0, 1'b0, 1'b1, 4'b1011);
    send_bits(16'b101, 3);
    check("ld_prog_before", int'(prog), 3);
    drive(1'b1, 1'b1, 1'b1, 4'b0110);
    check("ld_prog_after", int'(prog), 0);
    check("ld_match_after", int'(match), 0);
    send_bits(16'b0110, 4);
    check("ld_new_pat_match", int'(match), 1);

    // gaps in in_valid hold progress
    drive(1'b0, 1'b0, 1'b1, 4'b1011);
    overlap_en = 1'b1;
    drive(1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b1);
    check("gap_prog1", int'(prog), 1);
    drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1);
    check("gap_prog2", int'(prog), 2);
    drive(1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    check("gap_prog3", int'(prog), 3);
    drive(1'b1, 1'b1);
    check("gap_match", int'(match), 1);

    // asynchronous reset mid-stream restores RST_PAT and aborts progress
    drive(1'b0, 1'b0, 1'b1, 4'b1111);
    send_bits(16'b101, 3);
    check("ar_prog_pre", int'(prog), 1);
    #3 reset_n = 1'b0;
    #1;
    check("ar_match", int'(match), 0);
    check("ar_pulse", int'(match_pulse), 0);
    check("ar_prog", int'(prog), 0);
    check("ar_cnt", int'(match_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b1);
    check("ar_post_prog", int'(prog), 1);
    check("ar_post_match", int'(match), 0);
    drive(1'b1, 1'b0);
    check("ar_rst_pat", int'(prog), 2);

    repeat (3) drive(1'b0, 1'b0);
    checking_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
